// File: rtl/gray_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_histogram: per-frame 256-bin gray histogram, median threshold search, |
// | and double-buffered bar-graph rendering of the last completed frame.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module gray_histogram #(
  parameter int CNT_W      = 20,
  parameter int HIST_SHIFT = 10,
  parameter int CUM_SHIFT  = 12
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iFval,
  input  logic [7:0]  iGray,
  input  logic        iGray_Valid,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic        iDisp_Valid,
  output logic [7:0]  oHist,
  output logic [7:0]  oCumHist,
  output logic        oHist_Valid,
  output logic [7:0]  oThresholdLevel,
  output logic        oScan_Busy,
  output logic        oFrame_Skipped
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ACCUM = 2'd2,
    S_SCAN  = 2'd3
  } state_t;

  state_t           r_state;
  logic [7:0]       r_idx;
  logic             r_fval_d;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_cum;
  logic             r_found;
  logic [7:0]       r_thr_new;
  logic [7:0]       r_thr;
  logic             r_sel;
  logic             r_disp_ok;
  logic             r_busy;
  logic             r_skip;

  logic [CNT_W-1:0] r_bin   [0:255];
  logic [CNT_W-1:0] r_dhist [0:1][0:255];
  logic [CNT_W-1:0] r_dcum  [0:1][0:255];

  // Accumulate pipeline: stage A captures pixel and reads its bin, stage B writes.
  logic             r_a_v;
  logic [7:0]       r_a_g;
  logic [CNT_W-1:0] r_a_rd;
  logic             r_w_v;
  logic [7:0]       r_w_g;
  logic [CNT_W-1:0] r_w_cnt;

  logic             w_rise;
  logic             w_take;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_binv;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cum_next;
  logic [CNT_W-1:0] w_half;
  logic             w_hit;

  assign w_rise = iFval & ~r_fval_d;
  assign w_take = iGray_Valid & iFval &
                  ((r_state == S_ACCUM) | ((r_state == S_IDLE) & w_rise));

  // The read in stage A misses the write landing on the same edge; forward it.
  assign w_base = (r_w_v && (r_w_g == r_a_g)) ? r_w_cnt : r_a_rd;
  assign w_inc  = (w_base == c_cnt_max) ? w_base : w_base + CNT_W'(1);

  assign w_binv     = r_bin[r_idx];
  assign w_sum      = {1'b0, r_cum} + {1'b0, w_binv};
  assign w_cum_next = w_sum[CNT_W] ? c_cnt_max : w_sum[CNT_W-1:0];
  assign w_half     = r_total >> 1;
  assign w_hit      = (w_cum_next >= w_half);

  // Display read data
  logic [CNT_W-1:0] r_rd_h;
  logic [CNT_W-1:0] r_rd_c;

  always_ff @(posedge iClk) begin
    r_a_rd <= r_bin[iGray];
    if (r_a_v)
      r_bin[r_a_g] <= w_inc;
    else if ((r_state == S_CLEAR) || (r_state == S_SCAN))
      r_bin[r_idx] <= '0;
    if (r_state == S_SCAN) begin
      r_dhist[~r_sel][r_idx] <= w_binv;
      r_dcum[~r_sel][r_idx]  <= w_cum_next;
    end
    r_rd_h <= r_dhist[r_sel][iX_Cont[7:0]];
    r_rd_c <= r_dcum[r_sel][iX_Cont[7:0]];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= S_CLEAR;
      r_idx     <= 8'd0;
      r_fval_d  <= 1'b0;
      r_total   <= '0;
      r_cum     <= '0;
      r_found   <= 1'b0;
      r_thr_new <= 8'd0;
      r_thr     <= 8'd0;
      r_sel     <= 1'b0;
      r_disp_ok <= 1'b0;
      r_busy    <= 1'b0;
      r_skip    <= 1'b0;
      r_a_v     <= 1'b0;
      r_a_g     <= 8'd0;
      r_w_v     <= 1'b0;
      r_w_g     <= 8'd0;
      r_w_cnt   <= '0;
    end else begin
      r_fval_d <= iFval;
      r_skip   <= 1'b0;
      r_a_v    <= w_take;
      r_a_g    <= iGray;
      r_w_v    <= r_a_v;
      r_w_g    <= r_a_g;
      r_w_cnt  <= w_inc;
      if (r_a_v && (r_total != c_cnt_max))
        r_total <= r_total + CNT_W'(1);
      case (r_state)
        S_CLEAR: begin
          r_skip <= w_rise;
          r_idx  <= r_idx + 8'd1;
          r_busy <= (r_idx != 8'd255);
          if (r_idx == 8'd255)
            r_state <= S_IDLE;
        end
        S_IDLE: begin
          r_busy <= 1'b0;
          if (w_rise) begin
            r_state <= S_ACCUM;
            r_total <= '0;
          end
        end
        S_ACCUM: begin
          if (!iFval) begin
            r_state   <= S_SCAN;
            r_idx     <= 8'd0;
            r_cum     <= '0;
            r_found   <= 1'b0;
            r_thr_new <= 8'd0;
            r_busy    <= 1'b1;
          end
        end
        S_SCAN: begin
          r_skip <= w_rise;
          r_cum  <= w_cum_next;
          r_idx  <= r_idx + 8'd1;
          if (!r_found && w_hit) begin
            r_found   <= 1'b1;
            r_thr_new <= r_idx;
          end
          if (r_idx == 8'd255) begin
            // cum never falls below total/2 by the last bin, so an unset flag means 255
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_sel     <= ~r_sel;
            r_disp_ok <= 1'b1;
            r_thr     <= r_found ? r_thr_new : r_idx;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Display pipeline: stage 1 reads the live bank, stage 2 renders bars.
  logic       r_d1_v;
  logic       r_d1_in;
  logic       r_d1_ok;
  logic [7:0] r_d1_yinv;
  logic       r_hv;
  logic [7:0] r_h;
  logic [7:0] r_c;

  logic [CNT_W-1:0] w_hsh;
  logic [CNT_W-1:0] w_csh;
  logic [7:0]       w_hbar;
  logic [7:0]       w_cbar;

  assign w_hsh  = r_rd_h >> HIST_SHIFT;
  assign w_csh  = r_rd_c >> CUM_SHIFT;
  assign w_hbar = (w_hsh > CNT_W'(255)) ? 8'hFF : w_hsh[7:0];
  assign w_cbar = (w_csh > CNT_W'(255)) ? 8'hFF : w_csh[7:0];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_d1_v    <= 1'b0;
      r_d1_in   <= 1'b0;
      r_d1_ok   <= 1'b0;
      r_d1_yinv <= 8'd0;
      r_hv      <= 1'b0;
      r_h       <= 8'h00;
      r_c       <= 8'h00;
    end else begin
      r_d1_v    <= iDisp_Valid;
      r_d1_in   <= iDisp_Valid && (iX_Cont < 16'd256) && (iY_Cont < 16'd256);
      r_d1_ok   <= r_disp_ok;
      r_d1_yinv <= 8'd255 - iY_Cont[7:0];
      r_hv      <= r_d1_v;
      r_h       <= (r_d1_in && r_d1_ok && (r_d1_yinv < w_hbar)) ? 8'hFF : 8'h00;
      r_c       <= (r_d1_in && r_d1_ok && (r_d1_yinv < w_cbar)) ? 8'hFF : 8'h00;
    end
  end

  assign oHist           = r_h;
  assign oCumHist        = r_c;
  assign oHist_Valid     = r_hv;
  assign oThresholdLevel = r_thr;
  assign oScan_Busy      = r_busy;
  assign oFrame_Skipped  = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_gray_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gray_histogram: directed vectors for gray_histogram (CNT_W=12).          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_gray_histogram;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iFval = 1'b0;
  logic [7:0]  iGray = 8'd0;
  logic        iGray_Valid = 1'b0;
  logic [15:0] iX_Cont = 16'd0;
  logic [15:0] iY_Cont = 16'd0;
  logic        iDisp_Valid = 1'b0;
  logic [7:0]  oHist;
  logic [7:0]  oCumHist;
  logic        oHist_Valid;
  logic [7:0]  oThresholdLevel;
  logic        oScan_Busy;
  logic        oFrame_Skipped;

  int n_vec = 0;
  int n_err = 0;

  always #5 iClk = ~iClk;

  gray_histogram #(.CNT_W(12), .HIST_SHIFT(8), .CUM_SHIFT(10)) dut (
    .iClk(iClk), .iRst(iRst), .iFval(iFval), .iGray(iGray), .iGray_Valid(iGray_Valid),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iDisp_Valid(iDisp_Valid),
    .oHist(oHist), .oCumHist(oCumHist), .oHist_Valid(oHist_Valid),
    .oThresholdLevel(oThresholdLevel), .oScan_Busy(oScan_Busy),
    .oFrame_Skipped(oFrame_Skipped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic [7:0] eh, input logic [7:0] ec);
    @(negedge iClk);
    iDisp_Valid = 1'b1; iX_Cont = x[15:0]; iY_Cont = y[15:0];
    @(negedge iClk);
    iDisp_Valid = 1'b0; iX_Cont = 16'd0; iY_Cont = 16'd0;
    chk({tag, ".lat"}, oHist_Valid, 0);
    @(negedge iClk);
    chk({tag, ".v"}, oHist_Valid, 1);
    chk({tag, ".h"}, oHist, eh);
    chk({tag, ".c"}, oCumHist, ec);
  endtask

  task automatic send_frame(input int n, input bit ramp, input logic [7:0] g);
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      iFval = 1'b1; iGray_Valid = 1'b1;
      iGray = ramp ? i[7:0] : g;
    end
    @(negedge iClk);
    iFval = 1'b0; iGray_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!oScan_Busy && n < 8) begin @(negedge iClk); n++; end
    while (oScan_Busy && n < 600) begin @(negedge iClk); n++; end
    chk({tag, ".idle"}, oScan_Busy, 0);
    chk({tag, ".len"}, (n >= 250 && n <= 260), 1);
  endtask

  initial begin
    int skips;

    // Reset state
    repeat (3) @(negedge iClk);
    chk("rst.thr", oThresholdLevel, 0);
    chk("rst.busy", oScan_Busy, 0);
    chk("rst.skip", oFrame_Skipped, 0);
    chk("rst.hv", oHist_Valid, 0);
    chk("rst.h", oHist, 0);
    chk("rst.c", oCumHist, 0);
    iRst = 1'b0;
    wait_idle("clear0");
    probe("empty", 100, 255, 8'h00, 8'h00);

    // 1024 pixels of gray 100: bin 1024 -> hist bar 4, cum bar 1 from bin 100 on
    send_frame(1024, 1'b0, 8'd100);
    wait_idle("f1");
    chk("f1.thr", oThresholdLevel, 100);
    probe("f1.x100y255", 100, 255, 8'hFF, 8'hFF);
    probe("f1.x100y252", 100, 252, 8'hFF, 8'h00);
    probe("f1.x100y251", 100, 251, 8'h00, 8'h00);
    probe("f1.x99y255", 99, 255, 8'h00, 8'h00);
    probe("f1.x200y255", 200, 255, 8'h00, 8'hFF);
    probe("f1.x300", 300, 255, 8'h00, 8'h00);
    probe("f1.y400", 100, 400, 8'h00, 8'h00);

    // Ramp 0..255, then a frame starts at SCAN idx 10 and must be skipped
    send_frame(256, 1'b1, 8'd0);
    repeat (11) @(negedge iClk);
    iFval = 1'b1; iGray_Valid = 1'b1; iGray = 8'd200;
    skips = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge iClk);
      if (oFrame_Skipped) skips++;
    end
    iFval = 1'b0; iGray_Valid = 1'b0;
    chk("skip.count", skips, 1);
    chk("f2.busy", oScan_Busy, 0);
    chk("f2.thr", oThresholdLevel, 127);
    probe("f2.x100y255", 100, 255, 8'h00, 8'h00);
    probe("f2.x255y255", 255, 255, 8'h00, 8'h00);

    // Next frame counts normally; skipped gray-200 pixels must not appear
    send_frame(300, 1'b0, 8'd50);
    wait_idle("f3");
    chk("f3.thr", oThresholdLevel, 50);
    probe("f3.x50y255", 50, 255, 8'hFF, 8'h00);
    probe("f3.x200y255", 200, 255, 8'h00, 8'h00);

    // Saturation: 4101 pixels of gray 7 -> bin 4095 (bar 15), cum bar 3
    send_frame(4101, 1'b0, 8'd7);
    wait_idle("f4");
    chk("f4.thr", oThresholdLevel, 7);
    probe("f4.x7y241", 7, 241, 8'hFF, 8'h00);
    probe("f4.x7y240", 7, 240, 8'h00, 8'h00);
    probe("f4.x7y253", 7, 253, 8'hFF, 8'hFF);
    probe("f4.x7y252", 7, 252, 8'hFF, 8'h00);
    probe("f4.x8y253", 8, 253, 8'h00, 8'hFF);

    // Reset at SCAN idx 128 discards everything
    send_frame(200, 1'b0, 8'd30);
    repeat (129) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    chk("rst2.thr", oThresholdLevel, 0);
    chk("rst2.busy", oScan_Busy, 0);
    chk("rst2.skip", oFrame_Skipped, 0);
    chk("rst2.hv", oHist_Valid, 0);
    chk("rst2.h", oHist, 0);
    chk("rst2.c", oCumHist, 0);
    @(negedge iClk);
    iRst = 1'b0;
    wait_idle("clear2");
    chk("clear2.thr", oThresholdLevel, 0);
    probe("clear2.x7y253", 7, 253, 8'h00, 8'h00);

    send_frame(300, 1'b0, 8'd60);
    wait_idle("f5");
    chk("f5.thr", oThresholdLevel, 60);
    probe("f5.x60y255", 60, 255, 8'hFF, 8'h00);
    probe("f5.x60y254", 60, 254, 8'h00, 8'h00);
    probe("f5.x30y255", 30, 255, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
